// File: rtl/cmd_cfg_pkg.sv
// Shared types and constants for the command/configuration controller.
// CMD_CFG_STATUS_REG_EN (optional) adds the read-only status register at 0x0C.
package cmd_cfg_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_DUMP    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RESP_WAIT = 3'd1;
  localparam logic [2:0] ST_DMP_SETUP = 3'd2;
  localparam logic [2:0] ST_DMP_SEND  = 3'd3;
  localparam logic [2:0] ST_DMP_WAIT  = 3'd4;

  localparam logic [5:0] A_TRIG_CFG   = 6'h00;
  localparam logic [5:0] A_DECIMATOR  = 6'h01;
  localparam logic [5:0] A_VIH        = 6'h02;
  localparam logic [5:0] A_VIL        = 6'h03;
  localparam logic [5:0] A_MATCH_H    = 6'h04;
  localparam logic [5:0] A_MATCH_L    = 6'h05;
  localparam logic [5:0] A_MASK_H     = 6'h06;
  localparam logic [5:0] A_MASK_L     = 6'h07;
  localparam logic [5:0] A_BAUD_H     = 6'h08;
  localparam logic [5:0] A_BAUD_L     = 6'h09;
  localparam logic [5:0] A_TRIG_POS_H = 6'h0A;
  localparam logic [5:0] A_TRIG_POS_L = 6'h0B;
  localparam logic [5:0] A_STATUS     = 6'h0C;
  localparam logic [5:0] A_CH_BASE    = 6'h10;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

endpackage

// File: rtl/cfg_regfile.sv
// Configuration register storage and address decode.
// CMD_CFG_STATUS_REG_EN maps a read-only status byte at 0x0C.
module cfg_regfile
  import cmd_cfg_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int LOG2   = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [5:0]            addr,
  input  logic [7:0]            wdata,
  input  logic                  set_capture_done,
  output logic [7:0]            rd_data,
  output logic                  rd_ok,
  output logic                  wr_ok,
  output logic [5:0]            TrigCfg,
  output logic [NUM_CH*5-1:0]   ch_trig_cfg,
  output logic [3:0]            decimator,
  output logic [7:0]            VIH,
  output logic [7:0]            VIL,
  output logic [7:0]            matchH,
  output logic [7:0]            matchL,
  output logic [7:0]            maskH,
  output logic [7:0]            maskL,
  output logic [7:0]            baud_cntH,
  output logic [7:0]            baud_cntL,
  output logic [LOG2-1:0]       trig_pos
);

  logic [4:0] ch_cfg [NUM_CH];
  logic       ch_hit;

`ifdef CMD_CFG_STATUS_REG_EN
  localparam logic [3:0] NCH4 = 4'(NUM_CH);
`endif

  assign ch_hit = (addr[5:3] == 3'b010) && (int'(addr[2:0]) < NUM_CH);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign ch_trig_cfg[n*5 +: 5] = ch_cfg[n];
  end

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b1;
    wr_ok   = 1'b1;
    case (addr)
      A_TRIG_CFG:   rd_data = {2'b00, TrigCfg};
      A_DECIMATOR:  rd_data = {4'h0, decimator};
      A_VIH:        rd_data = VIH;
      A_VIL:        rd_data = VIL;
      A_MATCH_H:    rd_data = matchH;
      A_MATCH_L:    rd_data = matchL;
      A_MASK_H:     rd_data = maskH;
      A_MASK_L:     rd_data = maskL;
      A_BAUD_H:     rd_data = baud_cntH;
      A_BAUD_L:     rd_data = baud_cntL;
      A_TRIG_POS_H: rd_data = 8'(trig_pos >> 8);
      A_TRIG_POS_L: rd_data = trig_pos[7:0];
`ifdef CMD_CFG_STATUS_REG_EN
      A_STATUS: begin
        rd_data = {NCH4, 3'b000, TrigCfg[5]};
        wr_ok   = 1'b0;
      end
`endif
      default: begin
        // Only channel slots that exist are mapped; everything else NAKs.
        rd_ok = ch_hit;
        wr_ok = ch_hit;
        for (int n = 0; n < NUM_CH; n++) begin
          if (ch_hit && addr[2:0] == 3'(n)) rd_data = {3'b000, ch_cfg[n]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TrigCfg   <= 6'h03;
      decimator <= 4'h0;
      VIH       <= 8'hAA;
      VIL       <= 8'h55;
      matchH    <= 8'h00;
      matchL    <= 8'h00;
      maskH     <= 8'h00;
      maskL     <= 8'h00;
      baud_cntH <= 8'h06;
      baud_cntL <= 8'hC8;
      trig_pos  <= LOG2'(1);
      for (int n = 0; n < NUM_CH; n++) ch_cfg[n] <= 5'h01;
    end else begin
      if (wr_en && wr_ok) begin
        case (addr)
          A_TRIG_CFG:   ;
          A_DECIMATOR:  decimator <= wdata[3:0];
          A_VIH:        VIH       <= wdata;
          A_VIL:        VIL       <= wdata;
          A_MATCH_H:    matchH    <= wdata;
          A_MATCH_L:    matchL    <= wdata;
          A_MASK_H:     maskH     <= wdata;
          A_MASK_L:     maskL     <= wdata;
          A_BAUD_H:     baud_cntH <= wdata;
          A_BAUD_L:     baud_cntL <= wdata;
          A_TRIG_POS_H: trig_pos[LOG2-1:8] <= wdata[LOG2-9:0];
          A_TRIG_POS_L: trig_pos[7:0] <= wdata;
          default: begin
            for (int n = 0; n < NUM_CH; n++) begin
              if (ch_hit && addr[2:0] == 3'(n)) ch_cfg[n] <= wdata[4:0];
            end
          end
        endcase
      end
      // Capture-done wins over a simultaneous host write of bit 5.
      if (wr_en && addr == A_TRIG_CFG) TrigCfg <= {wdata[5] | set_capture_done, wdata[4:0]};
      else if (set_capture_done)       TrigCfg[5] <= 1'b1;
    end
  end

endmodule

// File: rtl/cmd_cfg_mc.sv
// Host command decoder: register read/write and capture RAM dump sequencing.
// CMD_CFG_STATUS_REG_EN enables the status register in cfg_regfile.
module cmd_cfg_mc
  import cmd_cfg_pkg::*;
#(
  parameter int NUM_CH  = 5,
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           cmd,
  input  logic                  cmd_rdy,
  input  logic                  resp_sent,
  input  logic                  set_capture_done,
  input  logic [NUM_CH*8-1:0]   rdata,
  input  logic [LOG2-1:0]       ram_addr,
  output logic [LOG2-1:0]       addr_ptr,
  output logic [5:0]            TrigCfg,
  output logic [NUM_CH*5-1:0]   ch_trig_cfg,
  output logic [3:0]            decimator,
  output logic [7:0]            VIH,
  output logic [7:0]            VIL,
  output logic [7:0]            matchH,
  output logic [7:0]            matchL,
  output logic [7:0]            maskH,
  output logic [7:0]            maskL,
  output logic [7:0]            baud_cntH,
  output logic [7:0]            baud_cntL,
  output logic [LOG2-1:0]       trig_pos,
  output logic [7:0]            resp,
  output logic                  send_resp,
  output logic                  clr_cmd_rdy,
  output logic [2:0]            state_dbg
);

  // Handshake: cmd is valid while cmd_rdy is high and is retired by a one-cycle
  // clr_cmd_rdy; each resp byte is valid for the single send_resp cycle and the
  // next byte is never issued before resp_sent acknowledges the previous one.

  state_t              state;
  op_e                 op;
  logic [NUM_CH-1:0]   mask_q;
  logic [NUM_CH-1:0]   pend;
  logic [NUM_CH-1:0]   sel_bit;
  logic [7:0]          sel_byte;
  logic [LOG2-1:0]     entry_cnt;
  logic [7:0]          rd_data;
  logic                rd_ok;
  logic                wr_ok;
  logic                wr_en;
  logic                mask_ok;

  assign op        = op_e'(cmd[15:14]);
  assign wr_en     = (state == ST_IDLE) && cmd_rdy && (op == OP_WRITE);
  assign mask_ok   = (cmd[7:0] != 8'h00) && ((cmd[7:0] >> NUM_CH) == 8'h00);
  assign state_dbg = state;

  function automatic logic [LOG2-1:0] wrap_inc(input logic [LOG2-1:0] a);
    return (a == LOG2'(ENTRIES - 1)) ? '0 : a + LOG2'(1);
  endfunction

  // Lowest pending channel is sent first, so scan from the top down.
  always_comb begin
    sel_byte = '0;
    sel_bit  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_byte   = rdata[i*8 +: 8];
        sel_bit    = '0;
        sel_bit[i] = 1'b1;
      end
    end
  end

  cfg_regfile #(.NUM_CH(NUM_CH), .LOG2(LOG2)) u_regs (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_en            (wr_en),
    .addr             (cmd[13:8]),
    .wdata            (cmd[7:0]),
    .set_capture_done (set_capture_done),
    .rd_data          (rd_data),
    .rd_ok            (rd_ok),
    .wr_ok            (wr_ok),
    .TrigCfg          (TrigCfg),
    .ch_trig_cfg      (ch_trig_cfg),
    .decimator        (decimator),
    .VIH              (VIH),
    .VIL              (VIL),
    .matchH           (matchH),
    .matchL           (matchL),
    .maskH            (maskH),
    .maskL            (maskL),
    .baud_cntH        (baud_cntH),
    .baud_cntL        (baud_cntL),
    .trig_pos         (trig_pos)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      resp        <= '0;
      send_resp   <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      addr_ptr    <= '0;
      mask_q      <= '0;
      pend        <= '0;
      entry_cnt   <= '0;
    end else begin
      send_resp   <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_rdy) begin
            send_resp <= 1'b1;
            state     <= ST_RESP_WAIT;
            case (op)
              OP_READ:  resp <= rd_ok ? rd_data : NAK;
              OP_WRITE: resp <= wr_ok ? ACK : NAK;
              OP_DUMP: begin
                if (mask_ok) begin
                  send_resp <= 1'b0;
                  mask_q    <= cmd[NUM_CH-1:0];
                  pend      <= cmd[NUM_CH-1:0];
                  addr_ptr  <= wrap_inc(ram_addr);
                  entry_cnt <= '0;
                  state     <= ST_DMP_SETUP;
                end else begin
                  resp <= NAK;
                end
              end
              default:  resp <= NAK;
            endcase
          end
        end
        ST_RESP_WAIT: begin
          if (resp_sent) begin
            clr_cmd_rdy <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_DMP_SETUP: state <= ST_DMP_SEND;
        ST_DMP_SEND: begin
          resp      <= sel_byte;
          send_resp <= 1'b1;
          pend      <= pend & ~sel_bit;
          state     <= ST_DMP_WAIT;
        end
        ST_DMP_WAIT: begin
          if (resp_sent) begin
            if (pend != '0) begin
              state <= ST_DMP_SEND;
            end else if (entry_cnt == LOG2'(ENTRIES - 1)) begin
              clr_cmd_rdy <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              addr_ptr  <= wrap_inc(addr_ptr);
              entry_cnt <= entry_cnt + LOG2'(1);
              pend      <= mask_q;
              state     <= ST_DMP_SETUP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_cfg_mc.sv
// Randomised scoreboard bench for cmd_cfg_mc with a register-map and RAM model.
`timescale 1ns/1ps
module tb_cmd_cfg_mc;

  localparam int NUM_CH  = 5;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
  localparam logic [7:0] T_ACK = 8'hA5;
  localparam logic [7:0] T_NAK = 8'hEE;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [15:0]         cmd = '0;
  logic                cmd_rdy = 1'b0;
  logic                resp_sent = 1'b0;
  logic                set_capture_done = 1'b0;
  logic [NUM_CH*8-1:0] rdata = '0;
  logic [LOG2-1:0]     ram_addr = '0;
  logic [LOG2-1:0]     addr_ptr;
  logic [5:0]          TrigCfg;
  logic [NUM_CH*5-1:0] ch_trig_cfg;
  logic [3:0]          decimator;
  logic [7:0]          VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL;
  logic [LOG2-1:0]     trig_pos;
  logic [7:0]          resp;
  logic                send_resp, clr_cmd_rdy;
  logic [2:0]          state_dbg;

  logic [7:0] exp_q[$];
  logic [7:0] mem [NUM_CH][ENTRIES];
  logic [7:0] m_reg [64];
  int n_cmp = 0;
  int n_err = 0;
  int clr_cnt = 0;

  cmd_cfg_mc #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp_sent(resp_sent),
    .set_capture_done(set_capture_done), .rdata(rdata), .ram_addr(ram_addr),
    .addr_ptr(addr_ptr), .TrigCfg(TrigCfg), .ch_trig_cfg(ch_trig_cfg),
    .decimator(decimator), .VIH(VIH), .VIL(VIL), .matchH(matchH), .matchL(matchL),
    .maskH(maskH), .maskL(maskL), .baud_cntH(baud_cntH), .baud_cntL(baud_cntL),
    .trig_pos(trig_pos), .resp(resp), .send_resp(send_resp),
    .clr_cmd_rdy(clr_cmd_rdy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // capture RAM with one cycle of read latency
  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) rdata[c*8 +: 8] <= mem[c][addr_ptr];
  end

  // UART side: acknowledge every byte after a random delay
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && send_resp) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && send_resp) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL resp_unexpected: got %0h expected no byte at %0t", resp, $time);
      end else begin
        check("resp", 32'(resp), 32'(exp_q.pop_front()));
      end
    end
    if (clr_cmd_rdy) clr_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic bit mapped(input int a);
    return (a <= 11) || (a >= 16 && a < 16 + NUM_CH);
  endfunction

  function automatic bit readable(input int a);
`ifdef CMD_CFG_STATUS_REG_EN
    if (a == 12) return 1'b1;
`endif
    return mapped(a);
  endfunction

  function automatic logic [7:0] fmask(input int a);
    if (a == 0) return 8'h3F;
    if (a == 1) return 8'h0F;
    if (a == 10) return 8'((1 << (LOG2 - 8)) - 1);
    if (a >= 16) return 8'h1F;
    return 8'hFF;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 64; a++) m_reg[a] = 8'h00;
    m_reg[0] = 8'h03; m_reg[2] = 8'hAA; m_reg[3] = 8'h55;
    m_reg[8] = 8'h06; m_reg[9] = 8'hC8; m_reg[11] = 8'h01;
    for (int c = 0; c < NUM_CH; c++) m_reg[16 + c] = 8'h01;
  endtask

  function automatic logic [7:0] model_cmd(input logic [15:0] c, input logic scd);
    int a = int'(c[13:8]);
    logic [7:0] d = c[7:0];
    logic [7:0] r = T_NAK;
    if (c[15:14] == 2'b00 && readable(a)) begin
      if (a == 12) r = 8'((NUM_CH % 16) << 4) | {7'b0, m_reg[0][5]};
      else         r = m_reg[a];
    end else if (c[15:14] == 2'b01 && mapped(a)) begin
      m_reg[a] = d & fmask(a);
      r = T_ACK;
    end
    if (scd) m_reg[0] = m_reg[0] | 8'h20;
    return r;
  endfunction

  task automatic check_cfg();
    logic [31:0] chx = '0;
    for (int c = 0; c < NUM_CH; c++) chx[c*5 +: 5] = m_reg[16 + c][4:0];
    check("TrigCfg", 32'(TrigCfg), 32'(m_reg[0]));
    check("decimator", 32'(decimator), 32'(m_reg[1]));
    check("VIH", 32'(VIH), 32'(m_reg[2]));
    check("VIL", 32'(VIL), 32'(m_reg[3]));
    check("matchH", 32'(matchH), 32'(m_reg[4]));
    check("matchL", 32'(matchL), 32'(m_reg[5]));
    check("maskH", 32'(maskH), 32'(m_reg[6]));
    check("maskL", 32'(maskL), 32'(m_reg[7]));
    check("baud_cntH", 32'(baud_cntH), 32'(m_reg[8]));
    check("baud_cntL", 32'(baud_cntL), 32'(m_reg[9]));
    check("trig_pos", 32'(trig_pos), (32'(m_reg[10]) << 8) | 32'(m_reg[11]));
    check("ch_trig_cfg", 32'(ch_trig_cfg), chx);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clr(input int budget, input string name);
    int n = 0;
    while (!clr_cmd_rdy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_clr_seen"}, 32'(clr_cmd_rdy), 32'd1);
  endtask

  task automatic send_cmd(input logic [15:0] c, input logic scd);
    exp_q.push_back(model_cmd(c, scd));
    @(negedge clk);
    cmd = c;
    cmd_rdy = 1'b1;
    set_capture_done = scd;
    @(negedge clk);
    set_capture_done = 1'b0;
    wait_clr(40, "cmd");
    cmd_rdy = 1'b0;
    @(negedge clk);
    check("clr_one_cycle", 32'(clr_cmd_rdy), 32'd0);
    check("idle_after_cmd", 32'(state_dbg), 32'd0);
    check_cfg();
  endtask

  task automatic do_dump(input logic [7:0] mask, input int start);
    for (int j = 1; j <= ENTRIES; j++) begin
      int a = (start + j) % ENTRIES;
      for (int c = 0; c < NUM_CH; c++) if (mask[c]) exp_q.push_back(mem[c][a]);
    end
    @(negedge clk);
    ram_addr = LOG2'(start);
    cmd = {2'b10, 6'h00, mask};
    cmd_rdy = 1'b1;
    @(negedge clk);
    check("dump_first_ptr", 32'(addr_ptr), 32'((start + 1) % ENTRIES));
    check("dump_setup_state", 32'(state_dbg), 32'd2);
    wait_clr(20000, "dump");
    cmd_rdy = 1'b0;
    check("dump_bytes_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("dump_idle", 32'(state_dbg), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] c;
    int clr0;
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int a = 0; a < ENTRIES; a++) mem[ch][a] = 8'($urandom_range(0, 255));
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_send_resp", 32'(send_resp), 32'd0);
    check("rst_clr", 32'(clr_cmd_rdy), 32'd0);
    check("rst_addr_ptr", 32'(addr_ptr), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check_cfg();

    send_cmd(16'h4205, 1'b0);
    send_cmd(16'h0200, 1'b0);
    send_cmd(16'h1600, 1'b0);
    send_cmd(16'h5600, 1'b0);
    send_cmd(16'hC000, 1'b0);
    send_cmd(16'h403A, 1'b1);
    send_cmd(16'h4001, 1'b1);
    send_cmd(16'h0C00, 1'b0);
    send_cmd(16'h4C11, 1'b0);
    send_cmd(16'h4AFF, 1'b0);
    send_cmd(16'h0A00, 1'b0);

    // stand-alone capture-done pulse while idle
    send_cmd(16'h4000, 1'b0);
    @(negedge clk);
    set_capture_done = 1'b1;
    @(negedge clk);
    set_capture_done = 1'b0;
    m_reg[0] = m_reg[0] | 8'h20;
    check_cfg();

    for (int i = 0; i < 40; i++) begin
      c = 16'($urandom_range(0, 65535));
      c[13:8] = 6'($urandom_range(0, 31));
      if (c[15:14] == 2'b10) c[7:0] = ($urandom_range(0, 1) != 0) ? 8'h00 : (c[7:0] | 8'h20);
      send_cmd(c, ($urandom_range(0, 7) == 0));
    end

    do_dump(8'h05, ENTRIES - 1);
    do_dump(8'($urandom_range(1, 31)), $urandom_range(0, ENTRIES - 1));

    // reset in the middle of a dump
    ram_addr = LOG2'($urandom_range(0, ENTRIES - 1));
    for (int j = 1; j <= ENTRIES; j++)
      for (int ch = 0; ch < NUM_CH; ch++) exp_q.push_back(mem[ch][(int'(ram_addr) + j) % ENTRIES]);
    @(negedge clk);
    cmd = 16'h801F;
    cmd_rdy = 1'b1;
    repeat (60) @(negedge clk);
    clr0 = clr_cnt;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    cmd_rdy = 1'b0;
    model_reset();
    check("midrst_resp", 32'(resp), 32'd0);
    check("midrst_send_resp", 32'(send_resp), 32'd0);
    check("midrst_clr", 32'(clr_cmd_rdy), 32'd0);
    check("midrst_addr_ptr", 32'(addr_ptr), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    check_cfg();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_clr", 32'(clr_cnt), 32'(clr0));
    send_cmd(16'h0200, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_cfg_mc.md
CMD_CFG_MC -- requirements
Module: cmd_cfg_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of capture channels (legal 1..8).
REQ-002 SHALL have parameter ENTRIES, default 384, depth of each channel RAM.
REQ-003 SHALL have parameter LOG2, default 9, RAM address width (legal 9..16, 2^LOG2 >= ENTRIES).
REQ-004 SHALL have port clk, input, 1, system clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port cmd, input, 16, host command: [15:14] op, [13:8] addr, [7:0] data or channel mask.
REQ-007 SHALL have ports cmd_rdy (in, 1), resp_sent (in, 1) and set_capture_done (in, 1), all as the UART and capture-control handshakes.
REQ-008 SHALL have port rdata, input, NUM_CH x 8 packed, RAM read data per channel; index 0 = CH1.
REQ-009 SHALL have port ram_addr, input, LOG2, last capture write address.
REQ-010 SHALL have port addr_ptr, output, LOG2, RAM read address.
REQ-011 SHALL have config outputs: TrigCfg (6), ch_trig_cfg (NUM_CH x 5), decimator (4), VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL (8 each), trig_pos (LOG2).
REQ-012 SHALL have outputs resp (8), send_resp (1) and clr_cmd_rdy (1), all registered.

Function
REQ-013 SHALL decode ops as 00 read, 01 write, 10 dump and 11 illegal; illegal returns NAK 0xEE.
REQ-014 SHALL use this register map: 0x00 TrigCfg; 0x01 decimator; 0x02 VIH; 0x03 VIL; 0x04 matchH; 0x05 matchL; 0x06 maskH; 0x07 maskL; 0x08 baud_cntH; 0x09 baud_cntL; 0x0A trig_pos[LOG2-1:8]; 0x0B trig_pos[7:0]; 0x10+n ch_trig_cfg[n] for n<NUM_CH. Writes truncate data to field width; reads zero-extend.
REQ-015 SHALL answer any unmapped addr, including 0x10+n with n>=NUM_CH, with NAK 0xEE on read or write, leaving all registers unchanged.
REQ-016 SHALL implement FSM states IDLE, RESP_WAIT, DMP_SETUP, DMP_SEND and DMP_WAIT; cmd_rdy is sampled only in IDLE, and cmd is held stable until clr_cmd_rdy.
REQ-017 SHALL, for read or write, in the cycle after cmd_rdy is seen in IDLE, drive resp (read data, 0xA5 write ack, or 0xEE) together with a 1-cycle send_resp pulse, then enter RESP_WAIT; the register update happens on that same edge.
REQ-018 SHALL, in RESP_WAIT on resp_sent, pulse clr_cmd_rdy for 1 cycle and return to IDLE.
REQ-019 SHALL treat dump cmd[7:0] as a channel mask; a mask that is zero or has bits >= NUM_CH set gives NAK, handled as REQ-017/018.
REQ-020 SHALL, on a valid dump, latch mask and start = ram_addr, load addr_ptr = start+1 (ENTRIES-1 wraps to 0), clear the entry counter, and enter DMP_SETUP.
REQ-021 SHALL hold DMP_SETUP for exactly 1 cycle to cover RAM read latency, then go to DMP_SEND.
REQ-022 SHALL, in DMP_SEND, register the rdata byte of the lowest pending mask channel onto resp, pulse send_resp and go to DMP_WAIT.
REQ-023 SHALL, in DMP_WAIT on resp_sent: go to DMP_SEND for the next pending mask channel; otherwise advance addr_ptr with wrap and go to DMP_SETUP; after ENTRIES addresses pulse clr_cmd_rdy and go to IDLE.
REQ-024 SHALL send exactly ENTRIES x popcount(mask) bytes per dump, oldest entry first, with the last entry = start and channels ascending within each address.
REQ-025 SHALL set TrigCfg[5] on set_capture_done in any state; if a write to 0x00 happens in the same cycle, it writes data[5:0] but bit 5 is forced to 1.
REQ-026 SHALL ignore resp_sent outside RESP_WAIT and DMP_WAIT.

Reset
REQ-027 SHALL reset to: TrigCfg=0x03, ch_trig_cfg[*]=0x01, decimator=0, VIH=0xAA, VIL=0x55, match/mask=0, baud_cntH=0x06, baud_cntL=0xC8, trig_pos=1, addr_ptr=0, resp=0, send_resp=0, clr_cmd_rdy=0, state=IDLE.
REQ-028 SHALL, on reset during a dump or response, abort immediately with no clr_cmd_rdy pulse.

Configuration
REQ-029 SHALL, with CMD_CFG_STATUS_REG_EN defined, make 0x0C a read-only status register reading {NUM_CH[3:0], 3'b000, TrigCfg[5]}, with writes to 0x0C returning NAK; without the macro, 0x0C is unmapped (NAK).

Structure
REQ-030 SHALL place the op enum, FSM state typedef, register address constants, and ACK (0xA5) and NAK (0xEE) constants in package cmd_cfg_pkg.
REQ-031 SHALL place register storage and address decode in sub-module cfg_regfile; dump sequencing and the FSM stay in cmd_cfg_mc.

Verification
REQ-032 SHALL cover: write 0x4205 (VIH=0x05) -> resp 0xA5; after resp_sent, 1 clr_cmd_rdy pulse; read 0x0200 -> resp 0x05.
REQ-033 SHALL cover: NUM_CH=5, read 0x1600 -> resp 0xEE, no register change; op 11 -> 0xEE.
REQ-034 SHALL cover: ENTRIES=384, ram_addr=383, dump 0x8005 -> addr_ptr starts at 0; 768 bytes alternate CH1,CH3; the final pair comes from address 383.
REQ-035 SHALL cover: set_capture_done together with write 0x403A -> TrigCfg=0x3A; together with write 0x4001 -> TrigCfg=0x21.
REQ-036 SHALL cover: rst_n low mid-dump -> all outputs at reset values, state IDLE, no clr_cmd_rdy.
REQ-037 SHALL cover: with CMD_CFG_STATUS_REG_EN, after capture done, read 0x0C00 -> 0x51; without it -> 0xEE.
